// File: rtl/epl_ffram_array_pipe.sv
// Purpose : FF-based FRAM row array with binary-addressed masked write, pipelined read and a row-sequential clear engine.
// Latency : read data, valid and tag appear RD_LAT (1 or 2) edges after the request; errors one edge after a reject/bad write.
// Backpr. : no stall path; accesses offered while pReady_o=0 (or in the pInit_i cycle) are dropped and flagged on pErr_o.
//
// Ports   : pClk_i/nRst_i clock and synchronous active-low reset; pInit_i starts a clear sweep;
//           pWe_i/pWaddr_i/pWmask_i/pDi_i masked row write; pRead_i/pRaddr_i row read request;
//           pTag_i sideband tag; pDto_o/pRvalid_o read result; pTag_o tag delayed RD_LAT;
//           pReady_o idle flag; pErr_o one-cycle pulse for out-of-range or rejected accesses.
// Option  : define EPL_FFRAM_WR_BYPASS_EN for write-first behaviour on same-row read+write.
module epl_ffram_array_pipe #(
   parameter int COLUMN = 8,
   parameter int ROW    = 16,
   parameter int ADDR_W = 4,
   parameter int RD_LAT = 1,
   parameter int TAG_W  = 4
) (
   input  logic              pClk_i,
   input  logic              nRst_i,
   input  logic              pInit_i,
   input  logic              pWe_i,
   input  logic [ADDR_W-1:0] pWaddr_i,
   input  logic [COLUMN-1:0] pWmask_i,
   input  logic [COLUMN-1:0] pDi_i,
   input  logic              pRead_i,
   input  logic [ADDR_W-1:0] pRaddr_i,
   input  logic [TAG_W-1:0]  pTag_i,
   output logic [COLUMN-1:0] pDto_o,
   output logic              pRvalid_o,
   output logic [TAG_W-1:0]  pTag_o,
   output logic              pReady_o,
   output logic              pErr_o
);

   typedef enum logic [0:0] {S_IDLE = 1'b0, S_CLEAR = 1'b1} state_t;

   // Extra bit so a ROW equal to 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0]   ROW_EXT  = (ADDR_W+1)'(ROW);
   localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(ROW - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_cnt;
   logic [COLUMN-1:0]   r_mem [ROW];

   logic [COLUMN-1:0]   r_dat [RD_LAT];
   logic                r_vld [RD_LAT];
   logic                r_oor [RD_LAT];
   logic [TAG_W-1:0]    r_tag [RD_LAT];
   logic                r_err1;

   logic                w_ready;
   logic                w_clr_en;
   logic                w_acc;
   logic                w_wr_inr;
   logic                w_rd_inr;
   logic                w_wr_go;
   logic                w_rd_go;
   logic                w_err_now;
   logic [COLUMN-1:0]   w_mem_rd;
   logic [COLUMN-1:0]   w_rd_dat;

   // Next-state and status decode.
   always_comb begin
      w_state_nxt = r_state;
      w_ready     = 1'b0;
      w_clr_en    = 1'b0;
      case (r_state)
         S_IDLE: begin
            w_ready = 1'b1;
            if (pInit_i) w_state_nxt = S_CLEAR;
         end
         S_CLEAR: begin
            w_clr_en = 1'b1;
            // pInit_i is deliberately not looked at here: no restart mid-sweep.
            if (r_cnt == LAST_ROW) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge pClk_i) begin
      if (!nRst_i) r_state <= S_IDLE;
      else         r_state <= w_state_nxt;
   end

   // The pInit_i cycle itself rejects accesses even though the array is still idle.
   assign w_acc     = w_ready & ~pInit_i;
   assign w_wr_inr  = {1'b0, pWaddr_i} < ROW_EXT;
   assign w_rd_inr  = {1'b0, pRaddr_i} < ROW_EXT;
   assign w_wr_go   = pWe_i & w_acc & w_wr_inr;
   assign w_rd_go   = pRead_i & w_acc;
   assign w_err_now = (pWe_i & ~(w_acc & w_wr_inr)) | (pRead_i & ~w_acc);

   assign w_mem_rd  = w_rd_inr ? r_mem[pRaddr_i] : '0;

   always_comb begin
      w_rd_dat = '0;
      if (w_rd_go) begin
         w_rd_dat = w_mem_rd;
`ifdef EPL_FFRAM_WR_BYPASS_EN
         // Write-first: an accepted write to the same row is merged into the read.
         // w_wr_go already implies an in-range address, so equality implies the read is in range.
         if (w_wr_go && (pWaddr_i == pRaddr_i))
            w_rd_dat = (w_mem_rd & ~pWmask_i) | (pDi_i & pWmask_i);
`endif
      end
   end

   // Storage and sweep counter. Clear and write never collide: writes are only accepted in IDLE.
   always_ff @(posedge pClk_i) begin
      if (!nRst_i) begin
         r_cnt <= '0;
         for (int r = 0; r < ROW; r++) r_mem[r] <= '0;
      end else begin
         if (w_clr_en) r_cnt <= r_cnt + 1'b1;
         else          r_cnt <= '0;

         if (w_clr_en)
            r_mem[r_cnt] <= '0;
         else if (w_wr_go)
            r_mem[pWaddr_i] <= (r_mem[pWaddr_i] & ~pWmask_i) | (pDi_i & pWmask_i);
      end
   end

   // Read/tag pipeline. Data is stored zeroed when there is no valid read, so the output needs no gating.
   always_ff @(posedge pClk_i) begin
      if (!nRst_i) begin
         r_err1 <= 1'b0;
         for (int i = 0; i < RD_LAT; i++) begin
            r_dat[i] <= '0;
            r_vld[i] <= 1'b0;
            r_oor[i] <= 1'b0;
            r_tag[i] <= '0;
         end
      end else begin
         r_err1   <= w_err_now;
         r_dat[0] <= w_rd_dat;
         r_vld[0] <= w_rd_go;
         r_oor[0] <= w_rd_go & ~w_rd_inr;
         r_tag[0] <= pTag_i;
         for (int i = 1; i < RD_LAT; i++) begin
            r_dat[i] <= r_dat[i-1];
            r_vld[i] <= r_vld[i-1];
            r_oor[i] <= r_oor[i-1];
            r_tag[i] <= r_tag[i-1];
         end
      end
   end

   assign pDto_o    = r_dat[RD_LAT-1];
   assign pRvalid_o = r_vld[RD_LAT-1];
   assign pTag_o    = r_tag[RD_LAT-1];
   assign pReady_o  = w_ready;
   // Out-of-range read errors travel with their data; write/reject errors take one edge. Coincident ones OR.
   assign pErr_o    = r_err1 | r_oor[RD_LAT-1];

endmodule

// File: tb/tb_epl_ffram_array_pipe.sv
// Bench for epl_ffram_array_pipe: two instances (ROW=16/RD_LAT=1 and ROW=12/RD_LAT=2) share one stimulus
// stream; a cycle-indexed expectation table built from the array/sweep rules is compared every cycle,
// plus a handful of directed checks with fixed expected values.
module tb_epl_ffram_array_pipe;

   localparam int NC = 2400;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   logic       nrst, init, we, rd;
   logic [3:0] waddr, raddr, tag;
   logic [7:0] wmask, di;

   logic [7:0] a_dto, b_dto;
   logic       a_rvld, b_rvld, a_rdy, b_rdy, a_err, b_err;
   logic [3:0] a_tag, b_tag;

   epl_ffram_array_pipe #(.COLUMN(8), .ROW(16), .ADDR_W(4), .RD_LAT(1), .TAG_W(4)) u_a (
      .pClk_i(clk), .nRst_i(nrst), .pInit_i(init), .pWe_i(we), .pWaddr_i(waddr),
      .pWmask_i(wmask), .pDi_i(di), .pRead_i(rd), .pRaddr_i(raddr), .pTag_i(tag),
      .pDto_o(a_dto), .pRvalid_o(a_rvld), .pTag_o(a_tag), .pReady_o(a_rdy), .pErr_o(a_err));

   epl_ffram_array_pipe #(.COLUMN(8), .ROW(12), .ADDR_W(4), .RD_LAT(2), .TAG_W(4)) u_b (
      .pClk_i(clk), .nRst_i(nrst), .pInit_i(init), .pWe_i(we), .pWaddr_i(waddr),
      .pWmask_i(wmask), .pDi_i(di), .pRead_i(rd), .pRaddr_i(raddr), .pTag_i(tag),
      .pDto_o(b_dto), .pRvalid_o(b_rvld), .pTag_o(b_tag), .pReady_o(b_rdy), .pErr_o(b_err));

`ifdef EPL_FFRAM_WR_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   int         n_chk = 0;
   int         n_err = 0;
   int         t = 0;
   bit         seen_rst = 1'b0;
   int         rows [2] = '{16, 12};
   int         lats [2] = '{1, 2};
   logic [7:0] mem  [2][16];
   int         busy [2];
   logic       exp_vld [2][NC+4];
   logic [7:0] exp_dat [2][NC+4];
   logic [3:0] exp_tag [2][NC+4];
   logic       exp_err [2][NC+4];

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, t, got, want);
      end
   endtask

   // Compare every output of both instances against the table for the current cycle.
   task automatic check_outputs();
      logic [7:0] g_dto;
      logic [3:0] g_tag;
      logic       g_vld, g_rdy, g_err;
      string      id;
      for (int k = 0; k < 2; k++) begin
         if (k == 0) begin g_dto = a_dto; g_vld = a_rvld; g_tag = a_tag; g_rdy = a_rdy; g_err = a_err; id = "a"; end
         else        begin g_dto = b_dto; g_vld = b_rvld; g_tag = b_tag; g_rdy = b_rdy; g_err = b_err; id = "b"; end
         chk({id, "_dto"},   32'(g_dto), 32'(exp_vld[k][t] ? exp_dat[k][t] : 8'h00));
         chk({id, "_rvld"},  32'(g_vld), 32'(exp_vld[k][t]));
         chk({id, "_tag"},   32'(g_tag), 32'(exp_tag[k][t]));
         chk({id, "_err"},   32'(g_err), 32'(exp_err[k][t]));
         chk({id, "_ready"}, 32'(g_rdy), 32'(busy[k] == 0));
      end
   endtask

   // Reference behaviour for one clock cycle of both instances, using the inputs now applied.
   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         if (!nrst) begin
            for (int r = 0; r < 16; r++) mem[k][r] = 8'h00;
            busy[k] = 0;
            for (int d = 1; d <= lats[k]; d++) begin
               exp_vld[k][t+d] = 1'b0; exp_dat[k][t+d] = 8'h00;
               exp_tag[k][t+d] = 4'h0; exp_err[k][t+d] = 1'b0;
            end
         end else begin
            bit         acc, wok, rok;
            logic [7:0] d;
            int         lt;
            lt  = t + lats[k];
            acc = (busy[k] == 0) && !init;
            wok = we && acc && (int'(waddr) < rows[k]);
            rok = rd && acc;
            if (we && !wok) exp_err[k][t+1] = 1'b1;
            if (rd && !rok) exp_err[k][t+1] = 1'b1;
            if (rok) begin
               exp_vld[k][lt] = 1'b1;
               if (int'(raddr) < rows[k]) begin
                  d = mem[k][raddr];
                  if (BYP && wok && (waddr == raddr)) d = (d & ~wmask) | (di & wmask);
               end else begin
                  d = 8'h00;
                  exp_err[k][lt] = 1'b1;
               end
               exp_dat[k][lt] = d;
            end
            exp_tag[k][lt] = tag;
            if (busy[k] > 0) begin
               mem[k][rows[k] - busy[k]] = 8'h00;
               busy[k] = busy[k] - 1;
            end else if (init) begin
               busy[k] = rows[k];
            end
            if (wok) mem[k][waddr] = (mem[k][waddr] & ~wmask) | (di & wmask);
         end
      end
      if (!nrst) seen_rst = 1'b1;
   endtask

   task automatic cyc(input logic rn, input logic in, input logic w, input logic [3:0] wa,
                      input logic [7:0] wm, input logic [7:0] d, input logic r,
                      input logic [3:0] ra, input logic [3:0] tg);
      @(negedge clk);
      if (seen_rst) check_outputs();
      nrst = rn; init = in; we = w; waddr = wa; wmask = wm; di = d; rd = r; raddr = ra; tag = tg;
      model_step();
      t++;
   endtask

   task automatic idle();
      cyc(1'b1, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 4'h0, 4'h0);
   endtask

   // Sample just after the edge that closes the cycle whose inputs were last driven.
   task automatic after_edge();
      @(posedge clk);
      #1;
   endtask

   initial begin
      int lo_a, lo_b;
      for (int k = 0; k < 2; k++) begin
         busy[k] = 0;
         for (int r = 0; r < 16; r++) mem[k][r] = 8'h00;
         for (int c = 0; c < NC + 4; c++) begin
            exp_vld[k][c] = 1'b0; exp_dat[k][c] = 8'h00; exp_tag[k][c] = 4'h0; exp_err[k][c] = 1'b0;
         end
      end
      nrst = 1'b0; init = 1'b0; we = 1'b0; rd = 1'b0;
      waddr = 4'h0; raddr = 4'h0; tag = 4'h0; wmask = 8'h00; di = 8'h00;

      cyc(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 4'h0, 4'h0);
      cyc(1'b0, 1'b0, 1'b0, 4'h0, 8'h00, 8'h00, 1'b0, 4'h0, 4'h0);
      after_edge();
      chk("rst_a_ready", 32'(a_rdy), 32'd1);
      chk("rst_b_dto",   32'(b_dto), 32'd0);
      idle();

      // Basic write then read at row 3.
      cyc(1'b1, 1'b0, 1'b1, 4'd3, 8'hFF, 8'hA5, 1'b0, 4'd0, 4'h0);
      cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd3, 4'h0);
      after_edge();
      chk("a5_a_dto",  32'(a_dto),  32'hA5);
      chk("a5_a_rvld", 32'(a_rvld), 32'd1);
      chk("a5_b_rvld_early", 32'(b_rvld), 32'd0);
      idle(); idle();

      // Partial mask on row 5.
      cyc(1'b1, 1'b0, 1'b1, 4'd5, 8'hFF, 8'hFF, 1'b0, 4'd0, 4'h0);
      cyc(1'b1, 1'b0, 1'b1, 4'd5, 8'h0F, 8'h00, 1'b0, 4'd0, 4'h0);
      cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd5, 4'h0);
      after_edge();
      chk("mask_a_dto", 32'(a_dto), 32'hF0);
      idle(); idle();

      // Fill with 0x5A, sweep, read mid-sweep, then read back zeros.
      for (int r = 0; r < 16; r++) cyc(1'b1, 1'b0, 1'b1, 4'(r), 8'hFF, 8'h5A, 1'b0, 4'd0, 4'h0);
      cyc(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0, 4'h0);
      lo_a = 0; lo_b = 0;
      for (int j = 0; j < 20; j++) begin
         if (j == 4) cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd7, 4'h0);
         else        idle();
         if (!a_rdy) lo_a++;
         if (!b_rdy) lo_b++;
         if (j == 4) begin
            after_edge();
            chk("sweep_rd_a_err",  32'(a_err),  32'd1);
            chk("sweep_rd_a_rvld", 32'(a_rvld), 32'd0);
         end
      end
      chk("sweep_len_a", 32'(lo_a), 32'd16);
      chk("sweep_len_b", 32'(lo_b), 32'd12);
      for (int r = 0; r < 16; r++) begin
         cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'(r), 4'h0);
         if (r == 9) begin
            after_edge();
            chk("swept_a_dto",  32'(a_dto),  32'h00);
            chk("swept_a_rvld", 32'(a_rvld), 32'd1);
         end
      end
      idle(); idle();

      // Out-of-range accesses (out of range for the 12-row instance only).
      cyc(1'b1, 1'b0, 1'b1, 4'd13, 8'hFF, 8'h77, 1'b0, 4'd0, 4'h0);
      after_edge();
      chk("oor_wr_b_err", 32'(b_err), 32'd1);
      chk("oor_wr_a_err", 32'(a_err), 32'd0);
      cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd14, 4'h0);
      idle();
      after_edge();
      chk("oor_rd_b_rvld", 32'(b_rvld), 32'd1);
      chk("oor_rd_b_err",  32'(b_err),  32'd1);
      chk("oor_rd_b_dto",  32'(b_dto),  32'd0);
      idle(); idle();

      // Same-cycle read and write of row 2.
      cyc(1'b1, 1'b0, 1'b1, 4'd2, 8'hFF, 8'h33, 1'b0, 4'd0, 4'h0);
      cyc(1'b1, 1'b0, 1'b1, 4'd2, 8'hFF, 8'hCC, 1'b1, 4'd2, 4'h0);
      after_edge();
      chk("rw_same_a_dto", 32'(a_dto), BYP ? 32'hCC : 32'h33);
      cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd2, 4'h0);
      after_edge();
      chk("rw_after_a_dto", 32'(a_dto), 32'hCC);
      idle(); idle();

      // Tag pipeline.
      cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0, 4'd1);
      cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0, 4'd2);
      cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0, 4'd3);
      after_edge();
      chk("tag_a", 32'(a_tag), 32'd3);
      chk("tag_b", 32'(b_tag), 32'd2);
      idle(); idle();

      // Reset in the middle of a sweep.
      cyc(1'b1, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b1, 4'd3, 4'h0);
      cyc(1'b1, 1'b1, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0, 4'h9);
      idle(); idle(); idle();
      cyc(1'b0, 1'b0, 1'b0, 4'd0, 8'h00, 8'h00, 1'b0, 4'd0, 4'h0);
      after_edge();
      chk("midrst_a_ready", 32'(a_rdy), 32'd1);
      chk("midrst_b_ready", 32'(b_rdy), 32'd1);
      chk("midrst_b_tag",   32'(b_tag), 32'd0);
      idle(); idle();

      // Randomised traffic.
      for (int i = 0; i < 1800; i++) begin
         cyc(($urandom_range(0, 199) != 0), ($urandom_range(0, 39) == 0),
             1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 8'($urandom),
             8'($urandom), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)));
      end
      idle(); idle(); idle();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/epl_ffram_array_pipe.md
Name: epl_ffram_array_pipe

Overview:
- Parametrised successor to the FF-based FRAM memory array.
- Replaces the one-hot wordline and column-enable interface with binary addressed write and read ports, a per-column write mask, and a configurable read pipeline (1 or 2 stages) with valid flag.
- Adds a row-sequential clear engine with a ready flag, and a sideband tag pipeline aligned to read latency.
- Sits between the FRAM controller and the bit-cell storage.

Parameters:
- COLUMN, 8, data width in bits (one row).
- ROW, 16, number of rows; need not be a power of two.
- ADDR_W, 4, address width; must satisfy 2**ADDR_W >= ROW.
- RD_LAT, 1, read latency in cycles; legal values 1 or 2.
- TAG_W, 4, sideband tag width.

Ports:
- pClk_i  in  1  clock; all logic on rising edge.
- nRst_i  in  1  synchronous active-low reset.
- pInit_i  in  1  start clear sweep (pulse).
- pWe_i  in  1  write request.
- pWaddr_i  in  ADDR_W  write row address.
- pWmask_i  in  COLUMN  per-column write enable.
- pDi_i  in  COLUMN  write data.
- pRead_i  in  1  read request.
- pRaddr_i  in  ADDR_W  read row address.
- pTag_i  in  TAG_W  sideband tag.
- pDto_o  out  COLUMN  read data.
- pRvalid_o  out  1  read data valid.
- pTag_o  out  TAG_W  tag delayed by RD_LAT.
- pReady_o  out  1  array idle and accepting accesses.
- pErr_o  out  1  out-of-range or rejected access, one-cycle pulse.

Behaviour:
- Reset: one clock and one synchronous, active-low reset. While nRst_i is low at a rising edge, the following are all forced to 0 on that edge:
  - all storage cells;
  - pDto_o, pRvalid_o, pTag_o, pErr_o and all pipeline stages;
  - sweep counter.
- pReady_o reset value is 1. FSM reset state is IDLE.
- Reset overrides everything, including a sweep in progress; no partial-state survives.
- FSM states:
  - IDLE: pReady_o=1. pInit_i=1 moves to CLEAR with row counter=0. Any same-cycle access is rejected.
  - CLEAR: pReady_o=0. Each cycle, row[counter] is cleared to 0 and the counter increments. After clearing row ROW-1, return to IDLE. Sweep takes exactly ROW cycles; pReady_o=1 on the following cycle.
  - pInit_i during CLEAR is ignored (no restart).
- Access rejection: a write or read presented while pReady_o=0 (or in the pInit_i cycle) is dropped. pErr_o=1 for one cycle, on the next edge. A rejected read produces no pRvalid_o.
- Write (IDLE, pWe_i=1, pWaddr_i<ROW): on the clock edge, row[pWaddr_i][c] <= pDi_i[c] for every c with pWmask_i[c]=1. Other columns hold their value. pWmask_i=0 is a legal no-op.
- Write with pWaddr_i>=ROW: storage unchanged; pErr_o pulses on the next cycle.
- Read (IDLE, pRead_i=1): the row is sampled combinationally from current storage in the request cycle. pDto_o and pRvalid_o=1 appear RD_LAT edges later.
- Read with pRaddr_i>=ROW: returns all zeros with pRvalid_o=1. pErr_o pulses in the same cycle as pRvalid_o.
- No read: pDto_o=0 and pRvalid_o=0 in the corresponding output cycle. Data is zeroed when not valid.
- Back-to-back reads: full throughput, one result per cycle in request order.
- Tag pipeline: pTag_o equals pTag_i delayed exactly RD_LAT cycles. It shifts unconditionally, independent of pRead_i and FSM state.
- Simultaneous read and write to the same row: read returns pre-write (old) data; the write still commits. See the optional feature below.
- pErr_o priority: if a write error and a read error map to the same output cycle, pErr_o is 1 (logical OR).

Optional Feature:
- Macro: EPL_FFRAM_WR_BYPASS_EN.
- Defined: on a same-cycle read and write to the same in-range row, read data is the merged value. Masked columns take pDi_i; unmasked columns take the stored value. This is write-first behaviour.
- Undefined: read-first (old data), as described above.
- Rejected accesses are never bypassed.

Test Plan:
- Reset, then write addr 3, data 0xA5, mask 0xFF; read addr 3 -> pDto_o=0xA5 and pRvalid_o=1 exactly RD_LAT cycles later; pDto_o=0x00 on idle cycles.
- Row 5 holds 0xFF; write 0x00 with mask 0x0F; read row 5 -> 0xF0.
- Pulse pInit_i after filling all rows with 0x5A -> pReady_o low for 16 cycles; a read issued mid-sweep gives pErr_o=1 and no valid; after the sweep, all rows read 0x00.
- ROW=12, ADDR_W=4: write addr 13 -> pErr_o pulse, no row changed; read addr 14 -> pDto_o=0, pRvalid_o=1, pErr_o=1 in the same cycle.
- Row 2=0x33; same-cycle write 0xCC (mask 0xFF) and read of addr 2 -> 0x33 without the macro, 0xCC with EPL_FFRAM_WR_BYPASS_EN; a following read gives 0xCC in both builds.
- RD_LAT=2: tag sequence 1,2,3 on consecutive cycles -> pTag_o shows 1,2,3 two cycles later; assert nRst_i low mid-sweep -> all outputs 0, pReady_o=1 on the next cycle.
